// File: rtl/hangman_pkg.sv
// Shared definitions for the hangman game controller.
//  - STATE_W : width of the exported state encoding
//  - state_t : controller states; S_LOAD is 0 so a cleared state reads as all zeros
//  - in_play : true in the states where the countdown runs and timeout can fire
package hangman_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      S_LOAD    = 3'd0,
      S_READY   = 3'd1,
      S_PLAY    = 3'd2,
      S_CHECK   = 3'd3,
      S_WIN     = 3'd4,
      S_LOSE    = 3'd5,
      S_TIMEOUT = 3'd6
   } state_t;

   function automatic logic in_play(input state_t s);
      return (s == S_PLAY) || (s == S_CHECK);
   endfunction

endpackage

// File: rtl/hangman_match.sv
// Parallel guess comparator and coverage check.
//  word_buf     in  : stored characters, entry i = position i
//  guess        in  : character under test
//  word_len     in  : number of valid positions
//  revealed     in  : positions already uncovered
//  match_vec    out : bit i = position i valid and equal to guess
//  len_mask     out : bit i = position i valid (i < word_len)
//  all_revealed out : every valid position is uncovered once match_vec is merged in
module hangman_match #(
   parameter int CHAR_W  = 5,
   parameter int MAX_LEN = 16,
   localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
   input  logic [MAX_LEN-1:0][CHAR_W-1:0] word_buf,
   input  logic [CHAR_W-1:0]              guess,
   input  logic [LEN_W-1:0]               word_len,
   input  logic [MAX_LEN-1:0]             revealed,
   output logic [MAX_LEN-1:0]             match_vec,
   output logic [MAX_LEN-1:0]             len_mask,
   output logic                           all_revealed
);

   genvar gi;
   generate
      for (gi = 0; gi < MAX_LEN; gi++) begin : g_pos
         assign len_mask[gi]  = (LEN_W'(gi) < word_len);
         assign match_vec[gi] = len_mask[gi] && (word_buf[gi] == guess);
      end
   endgenerate

   // Positions beyond word_len are don't-care for coverage.
   assign all_revealed = (((revealed | match_vec) & len_mask) == len_mask);

endmodule

// File: rtl/hangman_game_ctrl.sv
// Hangman game controller: word entry, guess checking, miss/time tracking.
//  clk, resetn         : clock; asynchronous active-high reset (name is historical)
//  load, endinput,
//  start, try, wipe    : level keys, each acts once on its 0->1 transition
//  char_in             : character to store (load) or to guess (try)
//  tick_en             : one-cycle countdown strobe
//  state_o             : current state (hangman_pkg::state_t encoding)
//  word_len            : characters stored
//  revealed            : bit i = position i uncovered
//  miss_count          : misses so far
//  time_left           : remaining ticks
//  hit/miss/repeat_pulse : one-cycle guess outcome, mutually exclusive
//  overflow            : sticky, load attempted with buffer full
//  win, lose, timeout  : terminal flags, held until wipe or reset
module hangman_game_ctrl
   import hangman_pkg::*;
#(
   parameter int CHAR_W     = 5,
   parameter int MAX_LEN    = 16,
   parameter int MAX_MISSES = 6,
   parameter int TIME_LIMIT = 60,
   localparam int LEN_W     = $clog2(MAX_LEN + 1),
   localparam int MISS_W    = $clog2(MAX_MISSES + 1),
   localparam int TIME_W    = (TIME_LIMIT > 0) ? $clog2(TIME_LIMIT + 1) : 1
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               load,
   input  logic [CHAR_W-1:0]  char_in,
   input  logic               endinput,
   input  logic               start,
   input  logic               try,
   input  logic               wipe,
   input  logic               tick_en,
   output logic [STATE_W-1:0] state_o,
   output logic [LEN_W-1:0]   word_len,
   output logic [MAX_LEN-1:0] revealed,
   output logic [MISS_W-1:0]  miss_count,
   output logic [TIME_W-1:0]  time_left,
   output logic               hit_pulse,
   output logic               miss_pulse,
   output logic               repeat_pulse,
   output logic               overflow,
   output logic               win,
   output logic               lose,
   output logic               timeout
);

   localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [TIME_W-1:0] TIME_RELOAD = TIME_W'(TIME_LIMIT);

   // Key edge detection: bit order {wipe, try, start, endinput, load}
   logic [4:0] key_vec;
   logic [4:0] key_prev_reg;
   logic [4:0] key_edge;
   assign key_vec  = {wipe, try, start, endinput, load};
   assign key_edge = key_vec & ~key_prev_reg;

   logic load_edge, endinput_edge, start_edge, try_edge, wipe_edge;
   assign load_edge     = key_edge[0];
   assign endinput_edge = key_edge[1];
   assign start_edge    = key_edge[2];
   assign try_edge      = key_edge[3];
   assign wipe_edge     = key_edge[4];

   state_t                          state_reg, state_next;
   logic [LEN_W-1:0]                word_len_reg, word_len_next;
   logic [MAX_LEN-1:0][CHAR_W-1:0]  word_buf_reg, word_buf_next;
   logic [MAX_LEN-1:0]              revealed_reg, revealed_next;
   logic [2**CHAR_W-1:0]            used_reg, used_next;
   logic [MISS_W-1:0]               miss_reg, miss_next;
   logic [TIME_W-1:0]               time_reg, time_next;
   logic [CHAR_W-1:0]               guess_reg, guess_next;
   logic                            hit_reg, hit_next;
   logic                            missp_reg, missp_next;
   logic                            rep_reg, rep_next;
   logic                            overflow_reg, overflow_next;
   logic                            win_reg, win_next;
   logic                            lose_reg, lose_next;
   logic                            timeout_reg, timeout_next;

   logic [MAX_LEN-1:0] match_vec;
   logic [MAX_LEN-1:0] len_mask;
   logic               all_revealed;
   logic               time_expired;
   logic [IDX_W-1:0]   wr_idx;

   hangman_match #(
      .CHAR_W  (CHAR_W),
      .MAX_LEN (MAX_LEN)
   ) u_match (
      .word_buf     (word_buf_reg),
      .guess        (guess_reg),
      .word_len     (word_len_reg),
      .revealed     (revealed_reg),
      .match_vec    (match_vec),
      .len_mask     (len_mask),
      .all_revealed (all_revealed)
   );

   assign time_expired = (TIME_LIMIT != 0) && (time_reg == '0);
   // Only used while word_len < MAX_LEN, so the truncation never loses a bit.
   assign wr_idx       = word_len_reg[IDX_W-1:0];

   always_comb begin
      state_next    = state_reg;
      word_len_next = word_len_reg;
      word_buf_next = word_buf_reg;
      revealed_next = revealed_reg;
      used_next     = used_reg;
      miss_next     = miss_reg;
      time_next     = time_reg;
      guess_next    = guess_reg;
      overflow_next = overflow_reg;
      win_next      = win_reg;
      lose_next     = lose_reg;
      timeout_next  = timeout_reg;
      hit_next      = 1'b0;
      missp_next    = 1'b0;
      rep_next      = 1'b0;

      if (wipe_edge) begin
         // Same end state as reset, taking effect on the next edge.
         state_next    = S_LOAD;
         word_len_next = '0;
         word_buf_next = '0;
         revealed_next = '0;
         used_next     = '0;
         miss_next     = '0;
         time_next     = TIME_RELOAD;
         guess_next    = '0;
         overflow_next = 1'b0;
         win_next      = 1'b0;
         lose_next     = 1'b0;
         timeout_next  = 1'b0;
      end else begin
         if (in_play(state_reg) && tick_en && (time_reg != '0)) begin
            time_next = time_reg - TIME_W'(1);
         end

         case (state_reg)
            S_LOAD: begin
               if (load_edge) begin
                  if (word_len_reg < LEN_W'(MAX_LEN)) begin
                     word_buf_next[wr_idx] = char_in;
                     word_len_next         = word_len_reg + LEN_W'(1);
                  end else begin
                     overflow_next = 1'b1;
                  end
               end
               if (endinput_edge && (word_len_reg != '0)) begin
                  state_next = S_READY;
               end
            end

            S_READY: begin
               if (start_edge) begin
                  state_next = S_PLAY;
                  time_next  = TIME_RELOAD;
               end
            end

            S_PLAY: begin
               // Expiry beats a guess arriving in the same cycle.
               if (time_expired) begin
                  state_next    = S_TIMEOUT;
                  timeout_next  = 1'b1;
                  revealed_next = len_mask;
               end else if (try_edge) begin
                  guess_next = char_in;
                  state_next = S_CHECK;
               end
            end

            S_CHECK: begin
               // Expiry also discards the pending check result.
               if (time_expired) begin
                  state_next    = S_TIMEOUT;
                  timeout_next  = 1'b1;
                  revealed_next = len_mask;
               end else if (used_reg[guess_reg]) begin
                  rep_next   = 1'b1;
                  state_next = S_PLAY;
               end else begin
                  used_next[guess_reg] = 1'b1;
                  if (match_vec != '0) begin
                     hit_next      = 1'b1;
                     revealed_next = revealed_reg | match_vec;
                     if (all_revealed) begin
                        state_next = S_WIN;
                        win_next   = 1'b1;
                     end else begin
                        state_next = S_PLAY;
                     end
                  end else begin
                     missp_next = 1'b1;
                     miss_next  = miss_reg + MISS_W'(1);
                     if (miss_reg == MISS_W'(MAX_MISSES - 1)) begin
                        state_next    = S_LOSE;
                        lose_next     = 1'b1;
                        revealed_next = len_mask;
                     end else begin
                        state_next = S_PLAY;
                     end
                  end
               end
            end

            default: begin
               // Terminal states hold until wipe or reset.
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         key_prev_reg <= '0;
         state_reg    <= S_LOAD;
         word_len_reg <= '0;
         word_buf_reg <= '0;
         revealed_reg <= '0;
         used_reg     <= '0;
         miss_reg     <= '0;
         time_reg     <= TIME_RELOAD;
         guess_reg    <= '0;
         hit_reg      <= 1'b0;
         missp_reg    <= 1'b0;
         rep_reg      <= 1'b0;
         overflow_reg <= 1'b0;
         win_reg      <= 1'b0;
         lose_reg     <= 1'b0;
         timeout_reg  <= 1'b0;
      end else begin
         key_prev_reg <= key_vec;
         state_reg    <= state_next;
         word_len_reg <= word_len_next;
         word_buf_reg <= word_buf_next;
         revealed_reg <= revealed_next;
         used_reg     <= used_next;
         miss_reg     <= miss_next;
         time_reg     <= time_next;
         guess_reg    <= guess_next;
         hit_reg      <= hit_next;
         missp_reg    <= missp_next;
         rep_reg      <= rep_next;
         overflow_reg <= overflow_next;
         win_reg      <= win_next;
         lose_reg     <= lose_next;
         timeout_reg  <= timeout_next;
      end
   end

   assign state_o      = state_reg;
   assign word_len     = word_len_reg;
   assign revealed     = revealed_reg;
   assign miss_count   = miss_reg;
   assign time_left    = time_reg;
   assign hit_pulse    = hit_reg;
   assign miss_pulse   = missp_reg;
   assign repeat_pulse = rep_reg;
   assign overflow     = overflow_reg;
   assign win          = win_reg;
   assign lose         = lose_reg;
   assign timeout      = timeout_reg;

endmodule

// File: tb/tb_hangman_game_ctrl.sv
// Scoreboard bench for hangman_game_ctrl: the stimulus side computes each guess
// outcome from the game rules and queues it; the monitor pops an entry whenever
// the DUT shows a guess pulse or a rising timeout flag.
module tb_hangman_game_ctrl;
   import hangman_pkg::*;

   localparam int CHAR_W     = 5;
   localparam int MAX_LEN    = 16;
   localparam int MAX_MISSES = 6;
   localparam int TIME_LIMIT = 3;

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic        load = 1'b0, endinput = 1'b0, start = 1'b0, try = 1'b0, wipe = 1'b0;
   logic        tick_en = 1'b0;
   logic [4:0]  char_in = '0;
   logic [2:0]  state_o;
   logic [4:0]  word_len;
   logic [15:0] revealed;
   logic [2:0]  miss_count;
   logic [1:0]  time_left;
   logic        hit_pulse, miss_pulse, repeat_pulse, overflow, win, lose, timeout;

   hangman_game_ctrl #(
      .CHAR_W     (CHAR_W),
      .MAX_LEN    (MAX_LEN),
      .MAX_MISSES (MAX_MISSES),
      .TIME_LIMIT (TIME_LIMIT)
   ) dut (
      .clk (clk), .resetn (resetn), .load (load), .char_in (char_in),
      .endinput (endinput), .start (start), .try (try), .wipe (wipe),
      .tick_en (tick_en), .state_o (state_o), .word_len (word_len),
      .revealed (revealed), .miss_count (miss_count), .time_left (time_left),
      .hit_pulse (hit_pulse), .miss_pulse (miss_pulse), .repeat_pulse (repeat_pulse),
      .overflow (overflow), .win (win), .lose (lose), .timeout (timeout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   function automatic void check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endfunction

   // flags bit order: {hit, miss, repeat, timeout, win, lose}
   typedef struct {
      int flags;
      int rev;
      int misses;
      int st;
      int cyc;
   } exp_t;

   exp_t sb_q[$];

   // ---------------- reference model (game rules) ----------------
   int word_q[$];
   bit used_m[32];
   int rev_m;
   int miss_m;
   int over_m;   // 0 while playing, else the terminal state code

   function automatic int full_mask();
      return (1 << word_q.size()) - 1;
   endfunction

   function automatic void model_new_game();
      word_q.delete();
      foreach (used_m[i]) used_m[i] = 1'b0;
      rev_m  = 0;
      miss_m = 0;
      over_m = 0;
   endfunction

   function automatic exp_t model_guess(input int g);
      exp_t e;
      bit   any;
      e.flags = 0;
      any     = 1'b0;
      if (used_m[g]) begin
         e.flags = 8;
      end else begin
         used_m[g] = 1'b1;
         foreach (word_q[i]) begin
            if (word_q[i] == g) begin
               rev_m = rev_m | (1 << i);
               any   = 1'b1;
            end
         end
         if (any) begin
            e.flags = 32;
            if (rev_m == full_mask()) begin
               over_m  = int'(S_WIN);
               e.flags = e.flags | 2;
            end
         end else begin
            miss_m  = miss_m + 1;
            e.flags = 16;
            if (miss_m == MAX_MISSES) begin
               over_m  = int'(S_LOSE);
               rev_m   = full_mask();
               e.flags = e.flags | 1;
            end
         end
      end
      e.rev    = rev_m;
      e.misses = miss_m;
      e.st     = (over_m != 0) ? over_m : int'(S_PLAY);
      e.cyc    = 0;
      return e;
   endfunction

   // ---------------- monitor ----------------
   logic to_prev = 1'b0;
   always @(negedge clk) begin : monitor
      exp_t e;
      if (hit_pulse || miss_pulse || repeat_pulse || (timeout && !to_prev)) begin
         check("event_expected", int'(sb_q.size() > 0), 1);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("flags", int'({hit_pulse, miss_pulse, repeat_pulse, timeout, win, lose}), e.flags);
            check("revealed", int'(revealed), e.rev);
            check("miss_count", int'(miss_count), e.misses);
            check("state", int'(state_o), e.st);
            check("latency_cycle", cyc, e.cyc);
         end
      end
      to_prev <= timeout;
   end

   // ---------------- stimulus helpers ----------------
   // k: 0 load, 1 endinput, 2 start, 3 try, 4 wipe
   task automatic press(input int k, input int c);
      @(posedge clk); #1;
      char_in = 5'(c);
      case (k)
         0: load = 1'b1;
         1: endinput = 1'b1;
         2: start = 1'b1;
         3: try = 1'b1;
         default: wipe = 1'b1;
      endcase
      @(posedge clk); #1;
      load = 1'b0; endinput = 1'b0; start = 1'b0; try = 1'b0; wipe = 1'b0;
   endtask

   task automatic do_load(input int c);
      press(0, c);
      word_q.push_back(c);
   endtask

   task automatic do_guess(input int g);
      exp_t e;
      @(posedge clk); #1;
      char_in = 5'(g);
      try     = 1'b1;
      e       = model_guess(g);
      e.cyc   = cyc + 2;
      sb_q.push_back(e);
      @(posedge clk); #1;
      try = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic new_word(input int a, input int b, input int c, input int n);
      press(4, 0);
      model_new_game();
      do_load(a);
      if (n > 1) do_load(b);
      if (n > 2) do_load(c);
      press(1, 0);
      press(2, 0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int c0;
      int len;
      int gcount;
      model_new_game();

      // reset state
      idle(3);
      resetn = 1'b0;
      idle(1);
      check("rst_outputs", int'({state_o, word_len, revealed, miss_count, hit_pulse, miss_pulse,
                                 repeat_pulse, overflow, win, lose, timeout}), 0);
      check("rst_time_left", int'(time_left), TIME_LIMIT);

      // 1: "CAT", guess 0 -> middle revealed
      do_load(2); do_load(0); do_load(19);
      press(1, 0);
      check("ready_state", int'(state_o), int'(S_READY));
      check("ready_len", int'(word_len), 3);
      press(2, 0);
      check("play_state", int'(state_o), int'(S_PLAY));
      check("play_time", int'(time_left), TIME_LIMIT);
      do_guess(0);

      // 2: finish the word, later tries and ticks ignored
      do_guess(2);
      do_guess(19);
      idle(2);
      check("win_state", int'(state_o), int'(S_WIN));
      press(3, 5);
      tick_en = 1'b1; idle(1); tick_en = 1'b0;
      idle(3);
      check("win_hold", int'({state_o, win}), int'({S_WIN, 1'b1}));
      check("win_time_frozen", int'(time_left), TIME_LIMIT);

      // 3: "A", six wrong letters -> lose
      press(4, 0);
      check("wipe_clears", int'({state_o, word_len, revealed, win}), 0);
      model_new_game();
      do_load(0);
      press(1, 0); press(2, 0);
      for (int g = 1; g <= 6; g++) do_guess(g);
      idle(2);

      // 4: repeat letter costs nothing
      new_word(2, 0, 19, 3);
      do_guess(5);
      do_guess(5);

      // 5: countdown expires with a try on the last tick cycle
      c0 = cyc;
      begin
         exp_t e;
         e.flags  = 4;
         e.rev    = full_mask();
         e.misses = miss_m;
         e.st     = int'(S_TIMEOUT);
         e.cyc    = c0 + 4;
         sb_q.push_back(e);
      end
      tick_en = 1'b1;
      @(posedge clk); #1;
      check("tick_dec", int'(time_left), TIME_LIMIT - 1);
      @(posedge clk); #1;
      char_in = 5'd0; try = 1'b1;
      @(posedge clk); #1;
      tick_en = 1'b0; try = 1'b0;
      check("time_zero", int'(time_left), 0);
      idle(3);
      check("timeout_hold", int'({state_o, timeout}), int'({S_TIMEOUT, 1'b1}));

      // 6: overflow, empty endinput, reset during check
      press(4, 0);
      model_new_game();
      for (int i = 0; i < 16; i++) press(0, i);
      check("full_no_ovf", int'({word_len, overflow}), int'({5'd16, 1'b0}));
      press(0, 20);
      check("overflow_set", int'({word_len, overflow}), int'({5'd16, 1'b1}));
      press(4, 0);
      check("overflow_wiped", int'(overflow), 0);
      press(1, 0);
      check("empty_endinput", int'(state_o), int'(S_LOAD));
      new_word(2, 0, 19, 3);
      do_guess(0);
      @(posedge clk); #1;
      char_in = 5'd2; try = 1'b1;
      @(posedge clk); #1;
      try = 1'b0;
      @(negedge clk);
      check("in_check", int'(state_o), int'(S_CHECK));
      resetn = 1'b1;
      #1;
      check("async_rst_outputs", int'({state_o, word_len, revealed, miss_count, hit_pulse,
                                      miss_pulse, repeat_pulse, overflow, win, lose, timeout}), 0);
      check("async_rst_time", int'(time_left), TIME_LIMIT);
      @(posedge clk); #1;
      resetn = 1'b0;
      idle(3);

      // randomized games
      for (int gnum = 0; gnum < 30; gnum++) begin
         press(4, 0);
         model_new_game();
         len = $urandom_range(1, 10);
         for (int i = 0; i < len; i++) do_load($urandom_range(0, 7));
         press(1, 0);
         press(2, 0);
         check("rand_word_len", int'(word_len), len);
         gcount = 0;
         while (over_m == 0 && gcount < 60) begin
            do_guess($urandom_range(0, 9));
            gcount++;
         end
         idle(2);
         check("rand_final_state", int'(state_o), (over_m != 0) ? over_m : int'(S_PLAY));
      end

      // drain scoreboard
      for (int i = 0; i < 20 && sb_q.size() > 0; i++) idle(1);
      check("scoreboard_drained", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
